// File: rtl/arbitrated_word_ram_pkg.sv
// Shared definitions for the arbitrated word RAM: default geometry, lane type and
// width helpers used by the top and the round-robin arbiter.
package arbitrated_word_ram_pkg;

   localparam int unsigned DEF_NUM_CH     = 2;
   localparam int unsigned DEF_WORD_DEPTH = 1024;
   localparam int unsigned DEF_ADDR_W     = 17;
   localparam int unsigned DEF_DATA_W     = 32;
   localparam int unsigned LANE_W         = 8;

   // One byte lane of a stored word
   typedef logic [LANE_W-1:0] lane_t;

   // Number of byte lanes in a word of dw bits
   function automatic int unsigned mem_lanes(input int unsigned dw);
      return dw / LANE_W;
   endfunction

   // Width of a channel index; a single channel still needs one bit
   function automatic int unsigned ch_idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/arbitrated_word_ram_rr_arbiter.sv
// Round-robin arbiter with bus lock for the arbitrated word RAM.
// Ports:
//   i_clock    rising-edge clock
//   i_reset    synchronous active-high reset; forces o_gnt to zero
//   i_req      per-channel request
//   i_lock     per-channel lock; a granted locked channel keeps ownership
//   i_advance  an access takes place at this edge (a grant is being used)
//   o_gnt      one-hot/zero grant, combinational
//   o_idx      index of the granted channel (meaningful only when o_gnt != 0)
module arbitrated_word_ram_rr_arbiter
   import arbitrated_word_ram_pkg::*;
#(
   parameter int unsigned NUM_CH = DEF_NUM_CH,
   localparam int unsigned IDX_W = ch_idx_w(NUM_CH)
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic [NUM_CH-1:0] i_req,
   input  logic [NUM_CH-1:0] i_lock,
   input  logic              i_advance,
   output logic [NUM_CH-1:0] o_gnt,
   output logic [IDX_W-1:0]  o_idx
);

   // r_ptr is the channel where the next search starts (last grant + 1)
   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W-1:0] r_owner;
   logic             r_owner_v;

   logic             w_found;
   logic [IDX_W-1:0] w_sel;
   logic [IDX_W-1:0] w_ptr_nxt;
   int unsigned      w_cand;

   // Grant selection: a locked, still-requesting owner wins; otherwise round-robin search
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      w_cand  = 0;
      if (r_owner_v && i_lock[r_owner] && i_req[r_owner]) begin
         w_found = 1'b1;
         w_sel   = r_owner;
      end else begin
         for (int unsigned k = 0; k < NUM_CH; k++) begin
            w_cand = (32'(r_ptr) + k) % NUM_CH;
            if (!w_found && i_req[IDX_W'(w_cand)]) begin
               w_found = 1'b1;
               w_sel   = IDX_W'(w_cand);
            end
         end
      end
      if (i_reset) begin
         w_found = 1'b0;
         w_sel   = '0;
      end
   end

   always_comb begin
      w_ptr_nxt = IDX_W'((32'(w_sel) + 1) % NUM_CH);
   end

   always_comb begin
      o_gnt = '0;
      if (w_found) begin
         o_gnt[w_sel] = 1'b1;
      end
      o_idx = w_sel;
   end

   // Pointer and ownership; ownership lapses at any edge without a locked access
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_ptr     <= '0;
         r_owner   <= '0;
         r_owner_v <= 1'b0;
      end else begin
         if (i_advance) begin
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_sel;
         end
         r_owner_v <= i_advance & i_lock[w_sel];
      end
   end

endmodule

// File: rtl/arbitrated_word_ram.sv
// Synchronous word RAM with byte-lane writes shared by NUM_CH requesters through a
// round-robin arbiter with bus lock. Reads are read-before-write; every granted access
// (read or write) is acknowledged by a one-cycle rvalid pulse.
// Ports:
//   i_clock   rising-edge clock
//   i_reset   synchronous active-high reset (RAM contents are not cleared)
//   i_req     per-channel request, held until granted
//   i_lock    per-channel bus lock
//   i_addr    per-channel word address, channel 0 in the most significant slice
//   i_wr_en   per-channel byte-lane write enables (bit k covers data bits [8k+7:8k])
//   i_wdata   per-channel write data
//   o_gnt     one-hot/zero grant, combinational
//   o_rdata   registered read data of the last granted access
//   o_rvalid  registered per-channel completion pulse
//   o_oob     registered per-channel out-of-range flag, pulses with o_rvalid
module arbitrated_word_ram
   import arbitrated_word_ram_pkg::*;
#(
   parameter int unsigned NUM_CH     = DEF_NUM_CH,
   parameter int unsigned WORD_DEPTH = DEF_WORD_DEPTH,
   parameter int unsigned ADDR_W     = DEF_ADDR_W,
   parameter int unsigned DATA_W     = DEF_DATA_W
) (
   input  logic                         i_clock,
   input  logic                         i_reset,
   input  logic [NUM_CH-1:0]            i_req,
   input  logic [NUM_CH-1:0]            i_lock,
   input  logic [NUM_CH*ADDR_W-1:0]     i_addr,
   input  logic [NUM_CH*DATA_W/8-1:0]   i_wr_en,
   input  logic [NUM_CH*DATA_W-1:0]     i_wdata,
   output logic [NUM_CH-1:0]            o_gnt,
   output logic [DATA_W-1:0]            o_rdata,
   output logic [NUM_CH-1:0]            o_rvalid,
   output logic [NUM_CH-1:0]            o_oob
);

   localparam int unsigned LANES = mem_lanes(DATA_W);
   localparam int unsigned IDX_W = ch_idx_w(NUM_CH);
   localparam int unsigned WA_W  = $clog2(WORD_DEPTH);

   logic [NUM_CH-1:0] w_gnt;
   logic [IDX_W-1:0]  w_idx;
   logic              w_adv;
   logic [ADDR_W-1:0] w_addr;
   logic [LANES-1:0]  w_we;
   logic [DATA_W-1:0] w_wdata;
   logic [WA_W-1:0]   w_word;
   logic              w_oob;
   logic [DATA_W-1:0] w_rword;

   arbitrated_word_ram_rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_arb (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_req     (i_req),
      .i_lock    (i_lock),
      .i_advance (w_adv),
      .o_gnt     (w_gnt),
      .o_idx     (w_idx)
   );

   assign o_gnt = w_gnt;

   // Grant is already suppressed during reset, so this also blocks writes at a reset edge
   assign w_adv = |w_gnt;

   // Route the granted channel's address, enables and data to the array
   always_comb begin
      w_addr  = '0;
      w_we    = '0;
      w_wdata = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_idx == IDX_W'(i)) begin
            w_addr  = i_addr[(NUM_CH-1-i)*ADDR_W +: ADDR_W];
            w_we    = i_wr_en[(NUM_CH-1-i)*LANES +: LANES];
            w_wdata = i_wdata[(NUM_CH-1-i)*DATA_W +: DATA_W];
         end
      end
   end

   // Upper address bits alias onto the array but are reported as out of range
   always_comb begin
      w_word = w_addr[WA_W-1:0];
      w_oob  = (w_addr >> WA_W) != '0;
   end

   // One array per byte lane so partial writes touch only their own lane
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      lane_t r_mem [WORD_DEPTH];

      always_ff @(posedge i_clock) begin
         if (w_adv && w_we[l]) begin
            r_mem[w_word] <= w_wdata[l*LANE_W +: LANE_W];
         end
      end

      assign w_rword[l*LANE_W +: LANE_W] = r_mem[w_word];
   end

   // Response registers; rdata holds its value when nothing is granted
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         o_rvalid <= '0;
         o_oob    <= '0;
         o_rdata  <= '0;
      end else begin
         o_rvalid <= w_gnt;
         o_oob    <= w_oob ? w_gnt : '0;
         if (w_adv) begin
            o_rdata <= w_rword;
         end
      end
   end

endmodule
